// File: rtl/bit_serializer_if.sv
// +----------------------------------------------------------------------+
// | bit_serializer_if : word-in / bit-out bus of the serializer           |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_bit;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  // Source side: offers words, watches the serial stream.
  modport master (
    output in_data, in_valid,
    input  in_ready, ser_bit, ser_valid, ser_last, busy
  );

  // Serializer side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_bit, ser_valid, ser_last, busy
  );
endinterface

`default_nettype wire

// File: rtl/bit_serializer.sv
// +----------------------------------------------------------------------+
// | bit_serializer : parallel-to-serial front end, one-word holding buffer|
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  wire logic       clk,
  input  wire logic       reset,
  bit_serializer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] hold_data, hold_data_n;
  logic             hold_full, hold_full_n;

  logic             accept;
  logic             at_last;
  logic [WIDTH-1:0] sreg_shifted;

  assign bus.in_ready = !hold_full && !reset;
  assign accept       = bus.in_valid && bus.in_ready;
  assign at_last      = (cnt == LAST_CNT);

  // Shift toward whichever end feeds ser_bit; vacated bit fills with 0.
  assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      cnt       <= cnt_n;
      hold_data <= hold_data_n;
      hold_full <= hold_full_n;
    end
  end

  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    cnt_n       = cnt;
    hold_data_n = hold_data;
    hold_full_n = hold_full;

    case (state)
      IDLE: begin
        // Bypass: a word taken while idle goes straight to the shifter.
        if (accept) begin
          sreg_n  = bus.in_data;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end

      SHIFT: begin
        if (!at_last) begin
          sreg_n = sreg_shifted;
          cnt_n  = cnt + 1'b1;
          if (accept) begin
            hold_data_n = bus.in_data;
            hold_full_n = 1'b1;
          end
        end else begin
          cnt_n = '0;
          if (hold_full) begin
            sreg_n      = hold_data;
            hold_full_n = 1'b0;
          end else if (accept) begin
            sreg_n = bus.in_data;
          end else begin
            state_n = IDLE;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.ser_valid = (state == SHIFT);
  assign bus.ser_bit   = (state == SHIFT)
                         ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0])
                         : IDLE_BIT;
  assign bus.ser_last  = (state == SHIFT) && at_last;
  assign bus.busy      = (state == SHIFT) || hold_full;

endmodule

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// +----------------------------------------------------------------------+
// | tb_bit_serializer : directed self-checking bench (MSB and LSB units)  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bit_serializer;

  localparam int W = 8;

  logic clk;
  logic reset;

  int n_vec;
  int n_err;

  bit_serializer_if #(.WIDTH(W)) ifa ();
  bit_serializer_if #(.WIDTH(W)) ifb ();

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid_a"}, 32'(ifa.ser_valid), 32'd0);
    chk({tag, "_bit_a"},   32'(ifa.ser_bit),   32'd0);
    chk({tag, "_last_a"},  32'(ifa.ser_last),  32'd0);
    chk({tag, "_busy_a"},  32'(ifa.busy),      32'd0);
    chk({tag, "_valid_b"}, 32'(ifb.ser_valid), 32'd0);
    chk({tag, "_bit_b"},   32'(ifb.ser_bit),   32'd0);
    chk({tag, "_busy_b"},  32'(ifb.busy),      32'd0);
  endtask

  logic [W-1:0] words [3];
  logic [W-1:0] wd;
  bit           b2b_seen;
  bit           b2b_done;

  initial begin
    n_vec = 0;
    n_err = 0;
    words[0] = 8'hFF;
    words[1] = 8'h00;
    words[2] = 8'hA5;
    reset        = 1'b1;
    ifa.in_valid = 1'b0;
    ifa.in_data  = '0;
    ifb.in_valid = 1'b0;
    ifb.in_data  = '0;

    // ---- Reset values ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("rst");
    chk("rst_ready_a", 32'(ifa.in_ready), 32'd0);
    chk("rst_ready_b", 32'(ifb.in_ready), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ifa.in_ready), 32'd1);
    chk("post_rst_busy",  32'(ifa.busy),     32'd0);

    // ---- Single word 8'hB6 into both units ----
    wd = 8'hB6;
    @(posedge clk); #1;
    ifa.in_data = wd; ifa.in_valid = 1'b1;
    ifb.in_data = wd; ifb.in_valid = 1'b1;
    @(posedge clk); #1;               // edge N accepted
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    ifa.in_data = 8'h5A; ifb.in_data = 8'h5A;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk($sformatf("msb_bit%0d", i),  32'(ifa.ser_bit),   32'(wd[W-1-i]));
      chk($sformatf("msb_vld%0d", i),  32'(ifa.ser_valid), 32'd1);
      chk($sformatf("msb_last%0d", i), 32'(ifa.ser_last),  32'(i == W-1));
      chk($sformatf("lsb_bit%0d", i),  32'(ifb.ser_bit),   32'(wd[i]));
      chk($sformatf("lsb_last%0d", i), 32'(ifb.ser_last),  32'(i == W-1));
    end
    @(negedge clk);
    chk_idle("after_word");

    // ---- Back-to-back streaming on the MSB unit ----
    b2b_seen = 1'b0;
    b2b_done = 1'b0;
    @(posedge clk); #1;
    fork
      begin : drv
        int k;
        bit acc;
        k = 0;
        ifa.in_data  = words[0];
        ifa.in_valid = 1'b1;
        for (int c = 0; c < 40 && k < 3; c++) begin
          @(negedge clk);
          acc = ifa.in_ready;
          @(posedge clk); #1;
          if (acc) begin
            k++;
            if (k < 3) ifa.in_data = words[k];
            else       ifa.in_valid = 1'b0;
          end
        end
        ifa.in_valid = 1'b0;
        chk("b2b_drv_done", 32'(k), 32'd3);
      end
      begin : mon
        for (int c = 0; c < 10 && !b2b_seen; c++) begin
          @(negedge clk);
          if (ifa.ser_valid) b2b_seen = 1'b1;
        end
        chk("b2b_start", 32'(b2b_seen), 32'd1);
        if (b2b_seen) begin
          for (int j = 0; j < 3*W; j++) begin
            if (j != 0) @(negedge clk);
            chk($sformatf("b2b_vld%0d", j),  32'(ifa.ser_valid), 32'd1);
            chk($sformatf("b2b_bit%0d", j),  32'(ifa.ser_bit),
                32'(words[j/W][W-1-(j%W)]));
            chk($sformatf("b2b_last%0d", j), 32'(ifa.ser_last),  32'((j%W) == W-1));
            chk($sformatf("b2b_rdy%0d", j),  32'(ifa.in_ready),
                32'(((j%W) == 0) || (j >= 2*W)));
          end
          @(negedge clk);
          chk("b2b_end_vld",  32'(ifa.ser_valid), 32'd0);
          chk("b2b_end_busy", 32'(ifa.busy),      32'd0);
        end
        b2b_done = 1'b1;
      end
    join

    // ---- Mid-word reset: 8'hF0 shifting, 8'h0F held ----
    @(posedge clk); #1;
    ifa.in_data = 8'hF0; ifa.in_valid = 1'b1;
    @(posedge clk); #1;               // F0 bypassed into shifter
    ifa.in_data = 8'h0F;
    @(posedge clk); #1;               // 0F into hold register
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_hold_busy",  32'(ifa.busy),     32'd1);
    chk("mid_hold_ready", 32'(ifa.in_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;               // bit index 3 on the line
    reset = 1'b1;
    #1;
    chk("mid_rst_vld",   32'(ifa.ser_valid), 32'd0);
    chk("mid_rst_bit",   32'(ifa.ser_bit),   32'd0);
    chk("mid_rst_busy",  32'(ifa.busy),      32'd0);
    chk("mid_rst_ready", 32'(ifa.in_ready),  32'd0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 2*W; i++) begin
      @(negedge clk);
      chk($sformatf("post_mid_vld%0d", i), 32'(ifa.ser_valid), 32'd0);
    end
    chk("post_mid_busy", 32'(ifa.busy), 32'd0);

    // ---- Downstream run-of-three detector fed with 8'hE0 ----
    @(posedge clk); #1;
    ifa.in_data = 8'hE0; ifa.in_valid = 1'b1;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    begin
      int  run;
      bit  z;
      run = 0;
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        z = ifa.ser_valid && ifa.ser_bit && (run == 2);
        chk($sformatf("det_z%0d", i), 32'(z), 32'(i == 2));
        if (ifa.ser_valid) run = ifa.ser_bit ? run + 1 : 0;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the serial run detector: accepts WIDTH-bit words through a valid/ready handshake and drives them out one bit per clock on `ser_bit`, which connects directly to the detector's `x` input. A one-word holding register allows back-to-back words to stream with no idle bit between them. Between words, the line idles at a fixed level so the detector sees a defined input.

## Interface
- `WIDTH`, 8: word width in bits; must be ≥ 2.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- `IDLE_BIT`, 1'b0: value driven on `ser_bit` when no word is being shifted.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `in_data` input WIDTH: parallel word; sampled on an accept edge.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block can take a word this cycle.
- `ser_bit` output 1: serial data; feeds detector `x`.
- `ser_valid` output 1: `ser_bit` carries a data bit this cycle.
- `ser_last` output 1: current bit is the final bit of its word.
- `busy` output 1: shifting, or holding register occupied.

## Operation
- **State:**
  - FSM with states IDLE and SHIFT.
  - Shift register `sreg` (WIDTH bits).
  - Bit counter `cnt`, width clog2(WIDTH), range 0..WIDTH-1.
  - Holding register `hold_data` plus flag `hold_full`.
- **Handshake:**
  - `in_ready` = !hold_full && !reset.
  - A word is accepted on a rising edge where `in_valid` && `in_ready`.
  - `in_data` may change freely when not accepted.
- **IDLE:**
  - `ser_valid` = 0, `ser_bit` = IDLE_BIT, `ser_last` = 0.
  - On accept, the word loads directly into `sreg`, `cnt` ← 0, and the FSM goes to SHIFT. This is the bypass path; `hold_full` stays 0.
- **SHIFT:**
  - `ser_valid` = 1.
  - `ser_bit` = sreg[WIDTH-1] if MSB_FIRST, else sreg[0].
  - `ser_last` = (cnt == WIDTH-1).
- **SHIFT, not last bit (each edge):**
  - `sreg` shifts toward the output end; the vacated bit fills with 0.
  - `cnt` increments.
  - An accepted word goes into `hold_data`, and `hold_full` ← 1.
- **SHIFT, last-bit edge — next word chosen by priority:**
  1. `hold_full`: `sreg` ← hold_data, `cnt` ← 0, `hold_full` ← 0, stay in SHIFT.
  2. Else, a word accepted this edge: `sreg` ← in_data, `cnt` ← 0, stay in SHIFT.
  3. Else: go to IDLE, `cnt` ← 0.
  - Simultaneous hold-to-shift transfer and new accept cannot occur, because `in_ready` = 0 while `hold_full` = 1.
- **`busy`:** (state == SHIFT) || hold_full.
- **Capacity:** at most two words are in the block (one shifting, one held). Overflow is impossible by construction.
- **Reset:**
  - While asserted: state IDLE, `cnt` = 0, `sreg` = 0, `hold_full` = 0, `hold_data` = 0.
  - Outputs: `ser_valid` = 0, `ser_bit` = IDLE_BIT, `ser_last` = 0, `busy` = 0, `in_ready` = 0.
  - Assertion mid-word discards both the in-flight and the held word; no partial bits follow deassertion.

## Timing
- **Latency:** a word accepted at edge N from IDLE puts its first bit on `ser_bit` in the cycle after edge N. Its last bit appears in the cycle after edge N+WIDTH-1.
- **Sustained rate:** one bit per clock. With `in_valid` held high, consecutive words are gapless: `ser_valid` stays 1 across word boundaries and `ser_last` pulses once every WIDTH cycles.
- **Source throughput:** `in_ready` deasserts the cycle after a word enters the hold register. It reasserts the cycle after the last-bit edge that drains the hold register.
- **Outputs:** all outputs are registered-state decodes (no combinational path from `in_data`), except `in_ready`, which also depends on `reset`.

## Test plan
- **Reset values:** assert reset → every output at its reset value, including `ser_bit` = IDLE_BIT. After deassertion, `in_ready` = 1 and `busy` = 0.
- **Single word, MSB-first:** WIDTH = 8, MSB_FIRST = 1, one word 8'hB6 accepted at edge N → `ser_bit` = 1,0,1,1,0,1,1,0 over cycles N+1..N+8.
  - `ser_valid` = 1 for exactly those 8 cycles; `ser_last` = 1 only in cycle N+8.
  - From cycle N+9, `ser_bit` = IDLE_BIT and `busy` = 0.
- **Single word, LSB-first:** MSB_FIRST = 0, word 8'hB6 → `ser_bit` = 0,1,1,0,1,1,0,1.
- **Back-to-back streaming:** `in_valid` held high with 8'hFF, 8'h00, 8'hA5 → 24 consecutive `ser_valid` cycles with no gap.
  - `ser_last` fires at bits 8, 16 and 24.
  - `in_ready` pattern per word: high, low for 7 cycles, high.
  - Bit stream exactly matches the three words.
- **Mid-word reset:** assert reset at bit 4 of 8'hF0 with 8'h0F held → `ser_valid` drops immediately. After deassertion, nothing is emitted until a new accept.
- **Downstream check:** stream 8'hE0 into the detector → detector `z` = 1 on the third 1-bit only, i.e. in the 3rd serial cycle.
